// File: rtl/rf_seq_pkg.sv
// Shared op codes, FunSel values, FSM encoding and enable decode for the rf_sequencer.
// RF_SEQ_SWAP_EN adds the WR2 state used by SWAP.
package rf_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LDI  = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_MOV  = 3'd5,
    OP_ADDK = 3'd6,
    OP_SWAP = 3'd7
  } op_e;

  localparam logic [1:0] FS_CLR  = 2'b00;
  localparam logic [1:0] FS_LOAD = 2'b01;
  localparam logic [1:0] FS_DEC  = 2'b10;
  localparam logic [1:0] FS_INC  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_WR1  = 3'd2,
    ST_RPT  = 3'd3
`ifdef RF_SEQ_SWAP_EN
    , ST_WR2 = 3'd4
`endif
  } state_e;

  // Register index within a bank to its MSB-first one-hot enable.
  function automatic logic [3:0] code_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = 4'b1000;
      2'd1:    oh = 4'b0100;
      2'd2:    oh = 4'b0010;
      2'd3:    oh = 4'b0001;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// Maps a 3-bit register code plus write enable onto the RSel/TSel enable vectors.
module rf_sel_decode
  import rf_seq_pkg::*;
(
  input  logic [2:0] i_code,
  input  logic       i_we,
  output logic [3:0] o_rsel,
  output logic [3:0] o_tsel
);

  // Code bit 2 picks the R bank; enables stay zero unless writing.
  always_comb begin
    o_rsel = 4'b0000;
    o_tsel = 4'b0000;
    if (i_we) begin
      if (i_code[2]) begin
        o_rsel = code_onehot(i_code[1:0]);
      end else begin
        o_tsel = code_onehot(i_code[1:0]);
      end
    end else begin
      o_rsel = 4'b0000;
      o_tsel = 4'b0000;
    end
  end

endmodule

// File: rtl/rf_sequencer.sv
// Command-driven microsequencer producing registered register-file control words.
// RF_SEQ_SWAP_EN enables op 111 as SWAP; otherwise op 111 reports err.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [2:0]   cmd_dst,
  input  logic [2:0]   cmd_src,
  input  logic [W-1:0] cmd_imm,
  input  logic [W-1:0] O1,
  input  logic [W-1:0] O2,
  output logic [W-1:0] I,
  output logic [2:0]   O1Sel,
  output logic [2:0]   O2Sel,
  output logic [1:0]   FunSel,
  output logic [3:0]   RSel,
  output logic [3:0]   TSel,
  output logic         done,
  output logic         err
);

  state_e       r_state;
  op_e          r_op;
  logic [2:0]   r_dst, r_src;
  logic [W-1:0] r_imm, r_cnt;
  logic         r_cmd_ready, r_done, r_err;
  logic [W-1:0] r_i;
  logic [2:0]   r_o1sel, r_o2sel;
  logic [1:0]   r_fun;
  logic [3:0]   r_rsel, r_tsel;
`ifdef RF_SEQ_SWAP_EN
  logic [W-1:0] r_hold_b;
`else
  logic         w_unused_o2;
  assign w_unused_o2 = ^O2;
`endif

  logic         w_accept;
  op_e          w_op;
  logic [2:0]   w_dst, w_src, w_code, w_o1sel, w_o2sel;
  logic [W-1:0] w_imm, w_next_cnt, w_i;
  state_e       w_next_state;
  logic         w_we, w_done, w_err;
  logic [1:0]   w_fun;
  logic [3:0]   w_rsel, w_tsel;

  // On accept the next word is decoded from the incoming fields, not the latch.
  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_op     = w_accept ? op_e'(cmd_op) : r_op;
  assign w_dst    = w_accept ? cmd_dst : r_dst;
  assign w_src    = w_accept ? cmd_src : r_src;
  assign w_imm    = w_accept ? cmd_imm : r_imm;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, repeat count and the control word for the coming cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_we         = 1'b0;
    w_code       = w_dst;
    w_fun        = FS_CLR;
    w_i          = '0;
    w_o1sel      = 3'b000;
    w_o2sel      = 3'b000;
    w_done       = 1'b0;
    w_err        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_MOV:  w_next_state = ST_RD1;
`ifdef RF_SEQ_SWAP_EN
            OP_SWAP: w_next_state = ST_RD1;
`endif
            OP_ADDK: begin
              if (w_imm == '0) begin
                w_next_state = ST_WR1;
              end else begin
                w_next_state = ST_RPT;
                w_next_cnt   = w_imm - W'(1);
              end
            end
            default: w_next_state = ST_WR1;
          endcase
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RD1: w_next_state = ST_WR1;
`ifdef RF_SEQ_SWAP_EN
      ST_WR1: w_next_state = (r_op == OP_SWAP) ? ST_WR2 : ST_IDLE;
      ST_WR2: w_next_state = ST_IDLE;
`else
      ST_WR1: w_next_state = ST_IDLE;
`endif
      ST_RPT: begin
        if (r_cnt == '0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - W'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // The I register captures O1 at the RD1 edge, so it doubles as hold_a.
    case (w_next_state)
      ST_RD1: begin
        w_o1sel = w_src;
        w_o2sel = w_dst;
      end
      ST_WR1: begin
        w_done = 1'b1;
        case (w_op)
          OP_CLR: begin w_we = 1'b1; w_fun = FS_CLR; end
          OP_LDI: begin w_we = 1'b1; w_fun = FS_LOAD; w_i = w_imm; end
          OP_INC: begin w_we = 1'b1; w_fun = FS_INC; end
          OP_DEC: begin w_we = 1'b1; w_fun = FS_DEC; end
          OP_MOV: begin w_we = 1'b1; w_fun = FS_LOAD; w_i = O1; end
`ifdef RF_SEQ_SWAP_EN
          OP_SWAP: begin w_we = 1'b1; w_fun = FS_LOAD; w_i = O1; w_done = 1'b0; end
`else
          OP_SWAP: w_err = 1'b1;
`endif
          default: w_we = 1'b0;
        endcase
      end
`ifdef RF_SEQ_SWAP_EN
      ST_WR2: begin
        w_we   = 1'b1;
        w_code = w_src;
        w_fun  = FS_LOAD;
        w_i    = r_hold_b;
        w_done = 1'b1;
      end
`endif
      ST_RPT: begin
        w_we   = 1'b1;
        w_fun  = FS_INC;
        w_done = (w_next_cnt == '0);
      end
      default: w_we = 1'b0;
    endcase
  end

  rf_sel_decode u_sel (
    .i_code (w_code),
    .i_we   (w_we),
    .o_rsel (w_rsel),
    .o_tsel (w_tsel)
  );

  // Command latch, counter, swap holding register and registered control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_NOP;
      r_dst       <= 3'd0;
      r_src       <= 3'd0;
      r_imm       <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_i         <= '0;
      r_o1sel     <= 3'd0;
      r_o2sel     <= 3'd0;
      r_fun       <= FS_CLR;
      r_rsel      <= 4'd0;
      r_tsel      <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef RF_SEQ_SWAP_EN
      r_hold_b    <= '0;
`endif
    end else begin
      r_op        <= w_op;
      r_dst       <= w_dst;
      r_src       <= w_src;
      r_imm       <= w_imm;
      r_cnt       <= w_next_cnt;
      r_cmd_ready <= (w_next_state == ST_IDLE);
      r_i         <= w_i;
      r_o1sel     <= w_o1sel;
      r_o2sel     <= w_o2sel;
      r_fun       <= w_fun;
      r_rsel      <= w_rsel;
      r_tsel      <= w_tsel;
      r_done      <= w_done;
      r_err       <= w_err;
`ifdef RF_SEQ_SWAP_EN
      r_hold_b    <= (r_state == ST_RD1) ? O2 : r_hold_b;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign I         = r_i;
  assign O1Sel     = r_o1sel;
  assign O2Sel     = r_o2sel;
  assign FunSel    = r_fun;
  assign RSel      = r_rsel;
  assign TSel      = r_tsel;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench: a behavioural register file plus a command-level reference model.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, done, err;
  logic [2:0] cmd_op, cmd_dst, cmd_src, O1Sel, O2Sel;
  logic [7:0] cmd_imm, O1, O2, I;
  logic [1:0] FunSel;
  logic [3:0] RSel, TSel;

  logic [7:0] rf     [8];
  logic [7:0] exp_rf [8];
  logic       rf_clr;

  int errors = 0;
  int checks = 0;

  logic [3:0] f_rsel, f_tsel;
  logic [1:0] f_fun;
  logic [7:0] f_i;
  logic [2:0] f_o1sel, f_o2sel;

  rf_sequencer #(.W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .O1(O1), .O2(O2), .I(I), .O1Sel(O1Sel), .O2Sel(O2Sel), .FunSel(FunSel),
    .RSel(RSel), .TSel(TSel), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register file: codes 0-3 are T1-T4, 4-7 are R1-R4, enables MSB-first.
  assign O1 = rf[O1Sel];
  assign O2 = rf[O2Sel];
  always @(posedge clk) begin
    for (int c = 0; c < 8; c++) begin
      if (rf_clr) rf[c] <= 8'h00;
      else if ((c >= 4) ? RSel[3 - (c % 4)] : TSel[3 - (c % 4)]) begin
        case (FunSel)
          2'b00:   rf[c] <= 8'h00;
          2'b01:   rf[c] <= I;
          2'b10:   rf[c] <= rf[c] - 8'd1;
          default: rf[c] <= rf[c] + 8'd1;
        endcase
      end
    end
  end

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [7:0] imm);
    int exp_cycles, exp_wr, cycles, wr, waited;
    logic exp_err, got, done_err, done_rdy, stray_err;
    logic [7:0] tmp;
    exp_err = 1'b0;
    case (op)
      3'd0: begin exp_cycles = 1; exp_wr = 0; end
      3'd5: begin exp_cycles = 2; exp_wr = 1; end
      3'd6: begin exp_cycles = (imm == 8'd0) ? 1 : int'(imm); exp_wr = int'(imm); end
      3'd7: begin
`ifdef RF_SEQ_SWAP_EN
        exp_cycles = 3; exp_wr = 2;
`else
        exp_cycles = 1; exp_wr = 0; exp_err = 1'b1;
`endif
      end
      default: begin exp_cycles = 1; exp_wr = 1; end
    endcase
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    f_o1sel = O1Sel; f_o2sel = O2Sel;
    f_rsel = 4'd0; f_tsel = 4'd0; f_fun = 2'd0; f_i = 8'd0;
    cycles = 0; wr = 0; got = 1'b0; done_err = 1'b0; done_rdy = 1'b0; stray_err = 1'b0;
    while (!got && cycles < 300) begin
      cycles++;
      if ((RSel | TSel) !== 4'b0000) begin
        if (wr == 0) begin f_rsel = RSel; f_tsel = TSel; f_fun = FunSel; f_i = I; end
        wr++;
      end
      if (done === 1'b1) begin
        got = 1'b1; done_err = err; done_rdy = cmd_ready;
      end else begin
        if (err !== 1'b0) stray_err = 1'b1;
        cmd_valid = 1'($urandom); cmd_op = 3'($urandom); cmd_dst = 3'($urandom);
        cmd_src = 3'($urandom); cmd_imm = 8'($urandom);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    case (op)
      3'd1: exp_rf[dst] = 8'h00;
      3'd2: exp_rf[dst] = imm;
      3'd3: exp_rf[dst] = exp_rf[dst] + 8'd1;
      3'd4: exp_rf[dst] = exp_rf[dst] - 8'd1;
      3'd5: exp_rf[dst] = exp_rf[src];
      3'd6: exp_rf[dst] = exp_rf[dst] + imm;
      3'd7: begin
`ifdef RF_SEQ_SWAP_EN
        tmp = exp_rf[dst]; exp_rf[dst] = exp_rf[src]; exp_rf[src] = tmp;
`endif
      end
      default: tmp = 8'h00;
    endcase
    checks++;
    if (!got) begin errors++; $display("FAIL done_seen op=%0d: no done within 300 cycles", op); end
    checks++;
    if (cycles != exp_cycles) begin errors++; $display("FAIL latency op=%0d: got %0d required %0d", op, cycles, exp_cycles); end
    checks++;
    if (wr != exp_wr) begin errors++; $display("FAIL write_cycles op=%0d: got %0d required %0d", op, wr, exp_wr); end
    checks++;
    if (done_err !== exp_err || stray_err !== 1'b0) begin
      errors++; $display("FAIL err op=%0d: got %b (stray %b) required %b", op, done_err, stray_err, exp_err);
    end
    checks++;
    if (done_rdy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready op=%0d: in done %b after %b required 0 then 1", op, done_rdy, cmd_ready);
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (rf[r] !== exp_rf[r]) begin
        errors++; $display("FAIL reg%0d op=%0d: got %h required %h", r, op, rf[r], exp_rf[r]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clr = 1'b1; cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0;
    for (int r = 0; r < 8; r++) exp_rf[r] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({RSel, TSel, FunSel, I, O1Sel, O2Sel, done, err} !== 32'd0) begin
      errors++; $display("FAIL reset_word: got %h required 0", {RSel, TSel, FunSel, I, O1Sel, O2Sel, done, err});
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", cmd_ready); end
    rst = 1'b0; rf_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready); end
  endtask

  task automatic test_ldi_mov();
    run_cmd(3'd2, 3'd5, 3'd0, 8'h18);
    checks++;
    if ({f_rsel, f_tsel, f_fun, f_i} !== {4'b0100, 4'b0000, 2'b01, 8'h18}) begin
      errors++; $display("FAIL ldi_word: got %h required %h", {f_rsel, f_tsel, f_fun, f_i}, {4'b0100, 4'b0000, 2'b01, 8'h18});
    end
    run_cmd(3'd5, 3'd3, 3'd5, 8'h00);
    checks++;
    if ({f_o1sel, f_o2sel, f_tsel, f_i} !== {3'b101, 3'b011, 4'b0001, 8'h18}) begin
      errors++; $display("FAIL mov_word: got %h required %h", {f_o1sel, f_o2sel, f_tsel, f_i}, {3'b101, 3'b011, 4'b0001, 8'h18});
    end
    run_cmd(3'd0, 3'd1, 3'd2, 8'h77);
  endtask

  task automatic test_addk();
    run_cmd(3'd2, 3'd6, 3'd0, 8'hFE);
    run_cmd(3'd6, 3'd6, 3'd0, 8'd3);
    checks++;
    if (rf[6] !== 8'h01) begin errors++; $display("FAIL addk_wrap: got %h required 01", rf[6]); end
    run_cmd(3'd6, 3'd6, 3'd0, 8'd0);
  endtask

  task automatic test_swap();
    run_cmd(3'd2, 3'd4, 3'd0, 8'h5E);
    run_cmd(3'd2, 3'd1, 3'd0, 8'hAA);
    run_cmd(3'd7, 3'd4, 3'd1, 8'h00);
    run_cmd(3'd7, 3'd4, 3'd4, 8'h00);
  endtask

  task automatic test_reset_mid_op();
    logic bad;
    run_cmd(3'd2, 3'd2, 3'd0, 8'h40);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_dst = 3'd2; cmd_src = 3'd0; cmd_imm = 8'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (TSel !== 4'b0010 || FunSel !== 2'b11 || done !== 1'b0) begin
      errors++; $display("FAIL rpt_word: got TSel=%b FunSel=%b done=%b required 0010 11 0", TSel, FunSel, done);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({RSel, TSel, FunSel, I, done, err, cmd_ready} !== 21'd0) begin
      errors++; $display("FAIL mid_reset_word: got %h required 0", {RSel, TSel, FunSel, I, done, err, cmd_ready});
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || (RSel | TSel) !== 4'b0000) bad = 1'b1;
    end
    exp_rf[2] = 8'h44;
    checks++;
    if (bad !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL after_reset_quiet: activity %b ready %b required 0 1", bad, cmd_ready);
    end
    checks++;
    if (rf[2] !== exp_rf[2]) begin errors++; $display("FAIL rpt_stopped: got %h required %h", rf[2], exp_rf[2]); end
  endtask

  task automatic test_back_to_back();
    int n_acc, first, second;
    logic r;
    n_acc = 0; first = -1; second = -1;
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0;
    for (int e = 0; e < 4; e++) begin
      r = cmd_ready;
      @(posedge clk);
      if (r === 1'b1) begin
        if (n_acc == 0) first = e; else second = e;
        n_acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    exp_rf[0] = exp_rf[0] + 8'd2;
    checks++;
    if (n_acc != 2 || second - first != 2) begin
      errors++; $display("FAIL b2b_accepts: got %0d gap %0d required 2 gap 2", n_acc, second - first);
    end
    checks++;
    if (rf[0] !== exp_rf[0]) begin errors++; $display("FAIL b2b_value: got %h required %h", rf[0], exp_rf[0]); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] imm;
    for (int n = 0; n < 30; n++) begin
      op  = 3'($urandom);
      imm = (op == 3'd6) ? 8'($urandom_range(0, 6)) : 8'($urandom);
      run_cmd(op, 3'($urandom), 3'($urandom), imm);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_mov();
    test_addk();
    test_swap();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
